video_obj_mem: RTL and testbench

//  Parametrised object store for the VPU: DEPTH entries of NUM_VERT-vertex objects + attribute field.

---
 rtl/vmu_pkg.sv | 35 +++
 rtl/video_obj_mem_if.sv | 49 ++++
 rtl/vmu_ldback_seq.sv | 103 ++++++++++
 rtl/video_obj_mem.sv | 128 ++++++++++++
 tb/tb_video_obj_mem.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vmu_pkg.sv
// Shared defaults, field-offset helpers and loadback FSM state type for video_obj_mem.
package vmu_pkg;

  localparam int unsigned ADDR_W_DEF   = 5;
  localparam int unsigned COORD_W_DEF  = 16;
  localparam int unsigned NUM_VERT_DEF = 4;
  localparam int unsigned ATTR_W_DEF   = 16;

  // Object word: NUM_VERT (x,y) pairs, attribute on top.
  function automatic int unsigned obj_w(input int unsigned coord_w, input int unsigned num_vert,
                                        input int unsigned attr_w);
    return 2 * coord_w * num_vert + attr_w;
  endfunction

  // Vertex index width; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned num_vert);
    return (num_vert > 1) ? $clog2(num_vert) : 1;
  endfunction

  function automatic int unsigned x_off(input int unsigned i, input int unsigned coord_w);
    return 2 * i * coord_w;
  endfunction

  function automatic int unsigned y_off(input int unsigned i, input int unsigned coord_w);
    return 2 * i * coord_w + coord_w;
  endfunction

  function automatic int unsigned attr_off(input int unsigned coord_w,
                                           input int unsigned num_vert);
    return 2 * coord_w * num_vert;
  endfunction

  typedef enum logic [1:0] {IDLE, FETCH, EMIT, DONE} ldb_state_t;

endpackage

// File: rtl/video_obj_mem_if.sv
// Bus bundle for video_obj_mem: matrix port, clip port, clear and loadback stream.
interface video_obj_mem_if #(
  parameter int unsigned ADDR_W   = vmu_pkg::ADDR_W_DEF,
  parameter int unsigned COORD_W  = vmu_pkg::COORD_W_DEF,
  parameter int unsigned NUM_VERT = vmu_pkg::NUM_VERT_DEF,
  parameter int unsigned ATTR_W   = vmu_pkg::ATTR_W_DEF
);
  localparam int unsigned OBJ_W = vmu_pkg::obj_w(COORD_W, NUM_VERT, ATTR_W);
  localparam int unsigned IDX_W = vmu_pkg::idx_w(NUM_VERT);

  logic [ADDR_W-1:0]  mat_addr;
  logic               mat_wr_en;
  logic [OBJ_W-1:0]   mat_obj_in;
  logic               mat_rd_en;
  logic [OBJ_W-1:0]   mat_obj_out;
  logic               mat_rd_vld;
  logic               mat_rd_hit;
  logic [ADDR_W-1:0]  clip_addr;
  logic               clip_rd_en;
  logic [OBJ_W-1:0]   clip_obj_out;
  logic               clip_rd_vld;
  logic               clip_rd_hit;
  logic               clr_all;
  logic               ldb_start;
  logic [ADDR_W-1:0]  ldb_addr;
  logic               ldb_busy;
  logic               ldb_vld;
  logic               ldb_rdy;
  logic [IDX_W-1:0]   ldb_idx;
  logic [COORD_W-1:0] ldb_x;
  logic [COORD_W-1:0] ldb_y;
  logic [ATTR_W-1:0]  ldb_attr;
  logic               ldb_done;

  modport master (
    output mat_addr, mat_wr_en, mat_obj_in, mat_rd_en, clip_addr, clip_rd_en, clr_all,
           ldb_start, ldb_addr, ldb_rdy,
    input  mat_obj_out, mat_rd_vld, mat_rd_hit, clip_obj_out, clip_rd_vld, clip_rd_hit,
           ldb_busy, ldb_vld, ldb_idx, ldb_x, ldb_y, ldb_attr, ldb_done
  );

  modport slave (
    input  mat_addr, mat_wr_en, mat_obj_in, mat_rd_en, clip_addr, clip_rd_en, clr_all,
           ldb_start, ldb_addr, ldb_rdy,
    output mat_obj_out, mat_rd_vld, mat_rd_hit, clip_obj_out, clip_rd_vld, clip_rd_hit,
           ldb_busy, ldb_vld, ldb_idx, ldb_x, ldb_y, ldb_attr, ldb_done
  );

endinterface

// File: rtl/vmu_ldback_seq.sv
// Loadback sequencer: snapshots one object into a shadow register and streams its vertices,
// one (x,y) per valid/ready beat, then pulses done.
module vmu_ldback_seq
  import vmu_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned COORD_W  = COORD_W_DEF,
  parameter int unsigned NUM_VERT = NUM_VERT_DEF,
  parameter int unsigned ATTR_W   = ATTR_W_DEF,
  localparam int unsigned OBJ_W   = obj_w(COORD_W, NUM_VERT, ATTR_W),
  localparam int unsigned IDX_W   = idx_w(NUM_VERT)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ldb_start_i,
  input  logic [ADDR_W-1:0]  ldb_addr_i,
  input  logic               ldb_rdy_i,
  output logic [ADDR_W-1:0]  fetch_addr_o,
  input  logic [OBJ_W-1:0]   fetch_data_i,
  output logic               busy_o,
  output logic               vld_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic [COORD_W-1:0] x_o,
  output logic [COORD_W-1:0] y_o,
  output logic [ATTR_W-1:0]  attr_o,
  output logic               done_o
);

  ldb_state_t        state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [OBJ_W-1:0]  shadow_q;
  logic [IDX_W-1:0]  idx_q;
  logic              busy_q;
  logic              vld_q;
  logic              done_q;

  // Sequencer FSM with registered busy/vld/done; shadow isolates EMIT from later RAM writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      shadow_q <= '0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      vld_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (ldb_start_i) begin
            addr_q  <= ldb_addr_i;
            busy_q  <= 1'b1;
            state_q <= FETCH;
          end
        end
        FETCH: begin
          shadow_q <= fetch_data_i;
          idx_q    <= '0;
          vld_q    <= 1'b1;
          state_q  <= EMIT;
        end
        EMIT: begin
          if (ldb_rdy_i) begin
            if (idx_q == IDX_W'(NUM_VERT - 1)) begin
              vld_q   <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Vertex mux: select the current beat's (x,y) out of the shadow word.
  always_comb begin
    x_o = '0;
    y_o = '0;
    for (int unsigned i = 0; i < NUM_VERT; i++) begin
      if (idx_q == IDX_W'(i)) begin
        x_o = shadow_q[x_off(i, COORD_W) +: COORD_W];
        y_o = shadow_q[y_off(i, COORD_W) +: COORD_W];
      end
    end
  end

  assign fetch_addr_o = addr_q;
  assign attr_o       = shadow_q[attr_off(COORD_W, NUM_VERT) +: ATTR_W];
  assign idx_o        = idx_q;
  assign busy_o       = busy_q;
  assign vld_o        = vld_q;
  assign done_o       = done_q;

endmodule

// File: rtl/video_obj_mem.sv
// Object store for the VPU: RAM of DEPTH objects, per-entry valid bitmap, matrix rd/wr port,
// clip rd port and a loadback sequencer.
// Build option: define VMU_WR_BYPASS_EN for write-first reads (default is read-first).
module video_obj_mem
  import vmu_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned COORD_W  = COORD_W_DEF,
  parameter int unsigned NUM_VERT = NUM_VERT_DEF,
  parameter int unsigned ATTR_W   = ATTR_W_DEF
) (
  input logic             clk,
  input logic             rst_n,
  video_obj_mem_if.slave  bus
);

  localparam int unsigned OBJ_W = obj_w(COORD_W, NUM_VERT, ATTR_W);
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [OBJ_W-1:0]  ram_q [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;

  logic [OBJ_W-1:0]  mat_obj_d, clip_obj_d, fetch_data;
  logic              mat_hit_d, clip_hit_d;
  logic [ADDR_W-1:0] fetch_addr;

  logic [OBJ_W-1:0]  mat_obj_q, clip_obj_q;
  logic              mat_hit_q, clip_hit_q, mat_vld_q, clip_vld_q;

  // Object storage; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (bus.mat_wr_en) begin
      ram_q[bus.mat_addr] <= bus.mat_obj_in;
    end
  end

  // Valid bitmap next state: clear first, so a same-cycle write still lands valid.
  always_comb begin
    valid_d = bus.clr_all ? '0 : valid_q;
    if (bus.mat_wr_en) begin
      valid_d[bus.mat_addr] = 1'b1;
    end
  end

  // Valid bitmap register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Read data selection for both ports and the sequencer fetch.
  always_comb begin
    mat_obj_d  = ram_q[bus.mat_addr];
    mat_hit_d  = valid_q[bus.mat_addr];
    clip_obj_d = ram_q[bus.clip_addr];
    clip_hit_d = valid_q[bus.clip_addr];
    fetch_data = ram_q[fetch_addr];
`ifdef VMU_WR_BYPASS_EN
    if (bus.mat_wr_en) begin
      mat_obj_d = bus.mat_obj_in;
      mat_hit_d = 1'b1;
      if (bus.clip_addr == bus.mat_addr) begin
        clip_obj_d = bus.mat_obj_in;
        clip_hit_d = 1'b1;
      end
      if (fetch_addr == bus.mat_addr) begin
        fetch_data = bus.mat_obj_in;
      end
    end
`endif
  end

  // Registered read ports: data/hit held until the next read on that port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mat_obj_q  <= '0;
      mat_hit_q  <= 1'b0;
      mat_vld_q  <= 1'b0;
      clip_obj_q <= '0;
      clip_hit_q <= 1'b0;
      clip_vld_q <= 1'b0;
    end else begin
      mat_vld_q  <= bus.mat_rd_en;
      clip_vld_q <= bus.clip_rd_en;
      if (bus.mat_rd_en) begin
        mat_obj_q <= mat_obj_d;
        mat_hit_q <= mat_hit_d;
      end
      if (bus.clip_rd_en) begin
        clip_obj_q <= clip_obj_d;
        clip_hit_q <= clip_hit_d;
      end
    end
  end

  assign bus.mat_obj_out  = mat_obj_q;
  assign bus.mat_rd_hit   = mat_hit_q;
  assign bus.mat_rd_vld   = mat_vld_q;
  assign bus.clip_obj_out = clip_obj_q;
  assign bus.clip_rd_hit  = clip_hit_q;
  assign bus.clip_rd_vld  = clip_vld_q;

  vmu_ldback_seq #(
    .ADDR_W   (ADDR_W),
    .COORD_W  (COORD_W),
    .NUM_VERT (NUM_VERT),
    .ATTR_W   (ATTR_W)
  ) u_ldback_seq (
    .clk          (clk),
    .rst_n        (rst_n),
    .ldb_start_i  (bus.ldb_start),
    .ldb_addr_i   (bus.ldb_addr),
    .ldb_rdy_i    (bus.ldb_rdy),
    .fetch_addr_o (fetch_addr),
    .fetch_data_i (fetch_data),
    .busy_o       (bus.ldb_busy),
    .vld_o        (bus.ldb_vld),
    .idx_o        (bus.ldb_idx),
    .x_o          (bus.ldb_x),
    .y_o          (bus.ldb_y),
    .attr_o       (bus.ldb_attr),
    .done_o       (bus.ldb_done)
  );

endmodule

// File: tb/tb_video_obj_mem.sv
// Self-checking bench for video_obj_mem against a behavioural array/bitmap model.
module tb_video_obj_mem;
  import vmu_pkg::*;

  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned COORD_W  = 16;
  localparam int unsigned NUM_VERT = 4;
  localparam int unsigned ATTR_W   = 16;
  localparam int unsigned OBJ_W    = obj_w(COORD_W, NUM_VERT, ATTR_W);
  localparam int unsigned IDX_W    = idx_w(NUM_VERT);
  localparam int unsigned DEPTH    = 2 ** ADDR_W;

  typedef logic [OBJ_W-1:0] obj_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  obj_t mem_m [DEPTH];
  bit   vld_m [DEPTH];

  video_obj_mem_if #(.ADDR_W(ADDR_W), .COORD_W(COORD_W), .NUM_VERT(NUM_VERT),
                     .ATTR_W(ATTR_W)) bus ();

  video_obj_mem #(.ADDR_W(ADDR_W), .COORD_W(COORD_W), .NUM_VERT(NUM_VERT),
                  .ATTR_W(ATTR_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // Coordinates numbered base, base+1, ... in order x0, y0, x1, y1, ...
  function automatic obj_t obj_seq(input int unsigned base, input logic [ATTR_W-1:0] attr);
    obj_t o = '0;
    for (int unsigned i = 0; i < 2 * NUM_VERT; i++) o[i*COORD_W +: COORD_W] = COORD_W'(base + i);
    o[OBJ_W-1 -: ATTR_W] = attr;
    return o;
  endfunction

  function automatic obj_t rand_obj();
    obj_t o;
    for (int unsigned i = 0; i < OBJ_W; i++) o[i] = 1'($urandom_range(0, 1));
    return o;
  endfunction

  function automatic logic [COORD_W-1:0] vert_x(input obj_t o, input int unsigned v);
    return o[2*v*COORD_W +: COORD_W];
  endfunction

  function automatic logic [COORD_W-1:0] vert_y(input obj_t o, input int unsigned v);
    return o[(2*v+1)*COORD_W +: COORD_W];
  endfunction

  function automatic logic [ATTR_W-1:0] obj_attr(input obj_t o);
    return o[OBJ_W-1 -: ATTR_W];
  endfunction

  task automatic idle_inputs();
    bus.mat_addr = '0; bus.mat_wr_en = 0; bus.mat_obj_in = '0; bus.mat_rd_en = 0;
    bus.clip_addr = '0; bus.clip_rd_en = 0; bus.clr_all = 0;
    bus.ldb_start = 0; bus.ldb_addr = '0; bus.ldb_rdy = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    repeat (3) @(negedge clk);
    checks++; if (bus.mat_rd_vld !== 1'b0) begin errors++;
      $display("FAIL reset_mat_vld got=%0b exp=0", bus.mat_rd_vld); end
    checks++; if (bus.mat_obj_out !== '0) begin errors++;
      $display("FAIL reset_mat_obj got=%h exp=0", bus.mat_obj_out); end
    checks++; if (bus.clip_rd_hit !== 1'b0) begin errors++;
      $display("FAIL reset_clip_hit got=%0b exp=0", bus.clip_rd_hit); end
    checks++; if ({bus.ldb_busy, bus.ldb_vld, bus.ldb_done} !== 3'b000) begin errors++;
      $display("FAIL reset_ldb_ctl got=%b exp=000", {bus.ldb_busy, bus.ldb_vld, bus.ldb_done}); end
    rst_n = 1;
    @(negedge clk);
    checks++; if (bus.ldb_busy !== 1'b0) begin errors++;
      $display("FAIL reset_idle_busy got=%0b exp=0", bus.ldb_busy); end
    for (int i = 0; i < int'(DEPTH); i++) vld_m[i] = 0;
  endtask

  task automatic test_write_read();
    obj_t o = obj_seq(1, 16'hA5C3);
    bus.mat_wr_en = 1; bus.mat_addr = 3; bus.mat_obj_in = o;
    @(negedge clk);
    mem_m[3] = o; vld_m[3] = 1;
    bus.mat_wr_en = 0; bus.mat_rd_en = 1;
    checks++; if (bus.mat_rd_vld !== 1'b0) begin errors++;
      $display("FAIL wr_rd_early_vld got=%0b exp=0", bus.mat_rd_vld); end
    @(negedge clk);
    bus.mat_rd_en = 0;
    checks++; if (bus.mat_rd_vld !== 1'b1) begin errors++;
      $display("FAIL wr_rd_vld got=%0b exp=1", bus.mat_rd_vld); end
    checks++; if (bus.mat_obj_out !== o) begin errors++;
      $display("FAIL wr_rd_data got=%h exp=%h", bus.mat_obj_out, o); end
    checks++; if (bus.mat_rd_hit !== 1'b1) begin errors++;
      $display("FAIL wr_rd_hit got=%0b exp=1", bus.mat_rd_hit); end
    @(negedge clk);
    checks++; if (bus.mat_rd_vld !== 1'b0) begin errors++;
      $display("FAIL wr_rd_pulse got=%0b exp=0", bus.mat_rd_vld); end
    checks++; if (bus.mat_obj_out !== o) begin errors++;
      $display("FAIL wr_rd_hold got=%h exp=%h", bus.mat_obj_out, o); end
  endtask

  task automatic test_clear();
    obj_t o = rand_obj();
    bus.clr_all = 1;
    @(negedge clk);
    for (int i = 0; i < int'(DEPTH); i++) vld_m[i] = 0;
    bus.clr_all = 0; bus.clip_rd_en = 1; bus.clip_addr = 3; bus.mat_rd_en = 1; bus.mat_addr = 7;
    @(negedge clk);
    bus.clip_rd_en = 0; bus.mat_rd_en = 0;
    checks++; if (bus.clip_obj_out !== mem_m[3]) begin errors++;
      $display("FAIL clr_clip_data got=%h exp=%h", bus.clip_obj_out, mem_m[3]); end
    checks++; if ({bus.clip_rd_vld, bus.clip_rd_hit} !== 2'b10) begin errors++;
      $display("FAIL clr_clip_vld_hit got=%b exp=10", {bus.clip_rd_vld, bus.clip_rd_hit}); end
    checks++; if ({bus.mat_rd_vld, bus.mat_rd_hit} !== 2'b10) begin errors++;
      $display("FAIL clr_unwritten_hit got=%b exp=10", {bus.mat_rd_vld, bus.mat_rd_hit}); end
    // Clear and write together: written entry survives as valid.
    bus.clr_all = 1; bus.mat_wr_en = 1; bus.mat_addr = 9; bus.mat_obj_in = o;
    @(negedge clk);
    mem_m[9] = o; vld_m[9] = 1;
    bus.clr_all = 0; bus.mat_wr_en = 0; bus.mat_rd_en = 1; bus.clip_rd_en = 1; bus.clip_addr = 3;
    @(negedge clk);
    bus.mat_rd_en = 0; bus.clip_rd_en = 0;
    checks++; if (bus.mat_rd_hit !== 1'b1 || bus.mat_obj_out !== o) begin errors++;
      $display("FAIL clr_wr_same got=%0b/%h exp=1/%h", bus.mat_rd_hit, bus.mat_obj_out, o); end
    checks++; if (bus.clip_rd_hit !== 1'b0) begin errors++;
      $display("FAIL clr_wr_other got=%0b exp=0", bus.clip_rd_hit); end
  endtask

  task automatic test_collision();
    obj_t a = rand_obj();
    obj_t b = rand_obj();
    obj_t exp_o;
    logic exp_h;
    bus.mat_wr_en = 1; bus.mat_addr = 5; bus.mat_obj_in = a;
    @(negedge clk);
    mem_m[5] = a; vld_m[5] = 1;
    bus.mat_wr_en = 0; bus.clr_all = 1;
    @(negedge clk);
    for (int i = 0; i < int'(DEPTH); i++) vld_m[i] = 0;
    bus.clr_all = 0; bus.mat_wr_en = 1; bus.mat_obj_in = b; bus.mat_rd_en = 1;
    bus.clip_rd_en = 1; bus.clip_addr = 5;
`ifdef VMU_WR_BYPASS_EN
    exp_o = b; exp_h = 1;
`else
    exp_o = a; exp_h = 0;
`endif
    @(negedge clk);
    mem_m[5] = b; vld_m[5] = 1;
    idle_inputs();
    checks++; if (bus.clip_obj_out !== exp_o || bus.clip_rd_hit !== exp_h) begin errors++;
      $display("FAIL collide_clip got=%0b/%h exp=%0b/%h", bus.clip_rd_hit, bus.clip_obj_out,
               exp_h, exp_o); end
    checks++; if (bus.mat_obj_out !== exp_o || bus.mat_rd_hit !== exp_h) begin errors++;
      $display("FAIL collide_mat got=%0b/%h exp=%0b/%h", bus.mat_rd_hit, bus.mat_obj_out,
               exp_h, exp_o); end
  endtask

  task automatic test_random();
    obj_t exp_mo, exp_co;
    logic exp_mh, exp_ch, exp_mv, exp_cv;
    for (int unsigned a = 0; a < DEPTH; a++) begin
      bus.mat_wr_en = 1; bus.mat_addr = ADDR_W'(a); bus.mat_obj_in = rand_obj();
      @(negedge clk);
      mem_m[a] = bus.mat_obj_in; vld_m[a] = 1;
    end
    for (int n = 0; n < 300; n++) begin
      bus.mat_wr_en  = ($urandom_range(0, 2) == 0);
      bus.mat_rd_en  = 1'($urandom_range(0, 1));
      bus.clip_rd_en = 1'($urandom_range(0, 1));
      bus.clr_all    = ($urandom_range(0, 15) == 0);
      bus.mat_addr   = ADDR_W'($urandom_range(0, 7));
      bus.clip_addr  = ADDR_W'($urandom_range(0, 7));
      bus.mat_obj_in = rand_obj();
      exp_mv = bus.mat_rd_en; exp_cv = bus.clip_rd_en;
      exp_mo = mem_m[bus.mat_addr];  exp_mh = vld_m[bus.mat_addr];
      exp_co = mem_m[bus.clip_addr]; exp_ch = vld_m[bus.clip_addr];
`ifdef VMU_WR_BYPASS_EN
      if (bus.mat_wr_en) begin
        exp_mo = bus.mat_obj_in; exp_mh = 1;
        if (bus.clip_addr == bus.mat_addr) begin exp_co = bus.mat_obj_in; exp_ch = 1; end
      end
`endif
      if (bus.clr_all) for (int i = 0; i < int'(DEPTH); i++) vld_m[i] = 0;
      if (bus.mat_wr_en) begin mem_m[bus.mat_addr] = bus.mat_obj_in; vld_m[bus.mat_addr] = 1; end
      @(negedge clk);
      checks++; if (bus.mat_rd_vld !== exp_mv || bus.clip_rd_vld !== exp_cv) begin errors++;
        $display("FAIL rand_vld n=%0d got=%0b%0b exp=%0b%0b", n, bus.mat_rd_vld,
                 bus.clip_rd_vld, exp_mv, exp_cv); end
      if (exp_mv) begin
        checks++; if (bus.mat_obj_out !== exp_mo || bus.mat_rd_hit !== exp_mh) begin errors++;
          $display("FAIL rand_mat n=%0d got=%0b/%h exp=%0b/%h", n, bus.mat_rd_hit,
                   bus.mat_obj_out, exp_mh, exp_mo); end
      end
      if (exp_cv) begin
        checks++; if (bus.clip_obj_out !== exp_co || bus.clip_rd_hit !== exp_ch) begin errors++;
          $display("FAIL rand_clip n=%0d got=%0b/%h exp=%0b/%h", n, bus.clip_rd_hit,
                   bus.clip_obj_out, exp_ch, exp_co); end
      end
    end
    idle_inputs();
  endtask

  // Call at a negedge; returns at the negedge where ldb_done is seen (or budget expiry).
  // mode 0: rdy always 1, 1: rdy pattern 1-0-0-1, 2: random rdy.
  task automatic run_ldb(input logic [ADDR_W-1:0] addr, input int mode, input bit ovw,
                         input string tag);
    obj_t snap = mem_m[addr];
    bit   pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int   beat = 0;
    int   k = 0;
    int   done_cyc = -1;
    bit   wrote = 0;
    bus.ldb_start = 1; bus.ldb_addr = addr; bus.ldb_rdy = (mode == 0);
    @(negedge clk);
    bus.ldb_start = 0;
    checks++; if ({bus.ldb_busy, bus.ldb_vld} !== 2'b10) begin errors++;
      $display("FAIL %s_fetch busy,vld got=%b exp=10", tag, {bus.ldb_busy, bus.ldb_vld}); end
    for (int cyc = 2; cyc < 60 && done_cyc < 0; cyc++) begin
      @(negedge clk);
      if (bus.mat_wr_en) begin
        mem_m[bus.mat_addr] = bus.mat_obj_in; vld_m[bus.mat_addr] = 1; bus.mat_wr_en = 0;
      end
      if (bus.ldb_done === 1'b1) begin
        done_cyc = cyc;
        checks++; if (beat != int'(NUM_VERT) || bus.ldb_vld !== 1'b0 || bus.ldb_busy !== 1'b1)
        begin errors++;
          $display("FAIL %s_done beats=%0d vld=%0b busy=%0b exp beats=%0d vld=0 busy=1", tag,
                   beat, bus.ldb_vld, bus.ldb_busy, NUM_VERT); end
      end else if (bus.ldb_vld === 1'b1) begin
        checks++;
        if (bus.ldb_idx !== IDX_W'(beat) || bus.ldb_x !== vert_x(snap, beat) ||
            bus.ldb_y !== vert_y(snap, beat) || bus.ldb_attr !== obj_attr(snap)) begin
          errors++;
          $display("FAIL %s_beat cyc=%0d got idx=%0d x=%h y=%h a=%h exp idx=%0d x=%h y=%h a=%h",
                   tag, cyc, bus.ldb_idx, bus.ldb_x, bus.ldb_y, bus.ldb_attr, beat,
                   vert_x(snap, beat), vert_y(snap, beat), obj_attr(snap));
        end
        if (ovw && !wrote) begin
          bus.mat_wr_en = 1; bus.mat_addr = addr; bus.mat_obj_in = rand_obj(); wrote = 1;
        end
        if (mode == 0)      bus.ldb_rdy = 1;
        else if (mode == 1) bus.ldb_rdy = pat[k % 4];
        else                bus.ldb_rdy = 1'($urandom_range(0, 1));
        k++;
        if (bus.ldb_rdy) beat++;
      end else begin
        checks++; errors++;
        $display("FAIL %s_gap cyc=%0d got vld=0 done=0 exp vld or done", tag, cyc);
      end
    end
    bus.mat_wr_en = 0;
    if (done_cyc < 0) begin
      checks++; errors++;
      $display("FAIL %s_timeout got=no_done exp=done", tag);
    end else if (mode == 0) begin
      checks++; if (done_cyc != int'(NUM_VERT) + 2) begin errors++;
        $display("FAIL %s_latency got=%0d exp=%0d", tag, done_cyc, NUM_VERT + 2); end
    end
  endtask

  task automatic test_loadback();
    bus.mat_wr_en = 1; bus.mat_addr = 3; bus.mat_obj_in = obj_seq(1, 16'hA5C3);
    @(negedge clk);
    mem_m[3] = bus.mat_obj_in; vld_m[3] = 1; bus.mat_wr_en = 0;
    run_ldb(3, 0, 0, "ldb");
    @(negedge clk);
    checks++; if ({bus.ldb_busy, bus.ldb_vld, bus.ldb_done} !== 3'b000) begin errors++;
      $display("FAIL ldb_after got=%b exp=000", {bus.ldb_busy, bus.ldb_vld, bus.ldb_done}); end
  endtask

  task automatic test_stall();
    run_ldb(3, 1, 1, "stall");
    @(negedge clk);
    checks++; if (bus.ldb_busy !== 1'b0) begin errors++;
      $display("FAIL stall_after busy got=%0b exp=0", bus.ldb_busy); end
    run_ldb(ADDR_W'($urandom_range(0, DEPTH - 1)), 2, 0, "rstall");
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    run_ldb(3, 0, 0, "b2b_a");
    bus.ldb_start = 1; bus.ldb_addr = 9;
    @(negedge clk);
    checks++; if (bus.ldb_busy !== 1'b0) begin errors++;
      $display("FAIL b2b_start_in_done busy got=%0b exp=0", bus.ldb_busy); end
    run_ldb(9, 0, 0, "b2b_b");
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit hit2 = 0;
    bus.ldb_start = 1; bus.ldb_addr = 3; bus.ldb_rdy = 1;
    for (int c = 0; c < 20 && !hit2; c++) begin
      @(negedge clk);
      bus.ldb_start = 0;
      if (bus.ldb_vld === 1'b1 && bus.ldb_idx === IDX_W'(2)) hit2 = 1;
    end
    checks++; if (!hit2) begin errors++;
      $display("FAIL rstmid_reach got=no_idx2 exp=idx2"); end
    rst_n = 0;
    #1;
    checks++; if ({bus.ldb_busy, bus.ldb_vld, bus.ldb_done} !== 3'b000) begin errors++;
      $display("FAIL rstmid_ctl got=%b exp=000", {bus.ldb_busy, bus.ldb_vld, bus.ldb_done}); end
    for (int i = 0; i < int'(DEPTH); i++) vld_m[i] = 0;
    idle_inputs();
    @(negedge clk);
    checks++; if ({bus.ldb_busy, bus.ldb_vld, bus.ldb_done} !== 3'b000) begin errors++;
      $display("FAIL rstmid_hold got=%b exp=000", {bus.ldb_busy, bus.ldb_vld, bus.ldb_done}); end
    rst_n = 1;
    @(negedge clk);
    run_ldb(3, 0, 0, "rstmid_rerun");
    @(negedge clk);
    bus.mat_rd_en = 1; bus.mat_addr = 3;
    @(negedge clk);
    bus.mat_rd_en = 0;
    checks++; if (bus.mat_rd_hit !== 1'b0 || bus.mat_obj_out !== mem_m[3]) begin errors++;
      $display("FAIL rstmid_ram got=%0b/%h exp=0/%h", bus.mat_rd_hit, bus.mat_obj_out,
               mem_m[3]); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_clear();
    test_collision();
    test_random();
    test_loadback();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
